// File: rtl/modbus_uart_pkg.sv
// Shared types and defaults for the Modbus RTU serial receive path.
package modbus_uart_pkg;
  localparam int unsigned DEF_BIT_CYCLES = 434;
  localparam int unsigned DEF_GAP_BITS   = 39;
  localparam int unsigned GAP_CNT_W      = 22;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;
endpackage

// File: rtl/modbus_gap_timer.sv
// Saturating idle counter; frame_end pulses once when LIMIT cycles of run elapse after a character.
// Registered pulse, LIMIT-1 cycles after the first run cycle; no backpressure.
module modbus_gap_timer
  import modbus_uart_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_GAP_BITS * DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic char_seen,
  output logic frame_end
);
  localparam logic [GAP_CNT_W-1:0] LAST = GAP_CNT_W'(LIMIT - 1);
  localparam logic [GAP_CNT_W-1:0] PRE  = GAP_CNT_W'(LIMIT - 2);

  logic [GAP_CNT_W-1:0] cnt;

  // Holding at LAST is what prevents a second pulse on a long idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (run && cnt != LAST) begin
        cnt <= cnt + 1'b1;
        if (cnt == PRE && char_seen) frame_end <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/modbus_uart_rx.sv
// UART byte receiver (8 data, optional even parity, 1 stop) with RTU inter-frame gap detection.
// Strobes ~(9.5+PARITY_EN)*BIT_CYCLES+4 cycles after the start edge; no backpressure.
module modbus_uart_rx
  import modbus_uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter bit          PARITY_EN  = 1'b0,
  parameter int unsigned GAP_BITS   = DEF_GAP_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       Enable,
  output logic       frame_err,
  output logic       parity_err,
  output logic       frame_end
);
  localparam logic [15:0] HALF_M1 = 16'(BIT_CYCLES / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BIT_CYCLES - 1);

  rx_state_t   state;
  logic        rx_m, rx_s, rx_d;
  logic        fall;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bad;
  logic        char_seen;
  logic        gap_clear, gap_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      char_seen  <= 1'b0;
      dataout    <= 8'h00;
      Enable     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      Enable     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (frame_end) char_seen <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            bit_cnt <= HALF_M1;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            bit_cnt <= FULL_M1;
            bit_idx <= '0;
            par_bad <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= FULL_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            par_bad <= rx_s ^ (^shreg);
            bit_cnt <= FULL_M1;
            state   <= STOP;
          end
        end
        STOP: begin
          // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            char_seen <= 1'b1;
            state     <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (par_bad) begin
              parity_err <= 1'b1;
            end else begin
              dataout <= shreg;
              Enable  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gap_clear = (state != IDLE) | fall;
  assign gap_run   = (state == IDLE) & rx_s;

  modbus_gap_timer #(
    .LIMIT (GAP_BITS * BIT_CYCLES)
  ) u_gap (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (gap_clear),
    .run       (gap_run),
    .char_seen (char_seen),
    .frame_end (frame_end)
  );
endmodule

// File: tb/tb_modbus_uart_rx.sv
// Randomized self-checking bench: two receivers (no parity / even parity) against a character-level event model.
module tb_modbus_uart_rx;
  localparam int BC    = 16;
  localparam int GAP   = 39;
  localparam int LIMIT = GAP * BC;
  localparam int K_EN  = 0;
  localparam int K_FE  = 1;
  localparam int K_PE  = 2;
  localparam int K_END = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx0   = 1'b1;
  logic       rx1   = 1'b1;
  logic [7:0] do0, do1;
  logic       en0, en1, fe0, fe1, pe0, pe1, end0, end1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int dut;
    int kind;
    int data;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  last_good[2];
  bit  pending[2];
  int  last_rise   = 0;
  int  last_strobe = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modbus_uart_rx #(.BIT_CYCLES(BC), .PARITY_EN(1'b0), .GAP_BITS(GAP)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .dataout(do0), .Enable(en0),
    .frame_err(fe0), .parity_err(pe0), .frame_end(end0)
  );

  modbus_uart_rx #(.BIT_CYCLES(BC), .PARITY_EN(1'b1), .GAP_BITS(GAP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .dataout(do1), .Enable(en1),
    .frame_err(fe1), .parity_err(pe1), .frame_end(end1)
  );

  function automatic ev_t mk(input int dut, input int kind, input int data, input int c);
    ev_t e;
    e.dut  = dut;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (en0)  obs_q.push_back(mk(0, K_EN, int'(do0), cyc));
      if (fe0)  obs_q.push_back(mk(0, K_FE, 0, cyc));
      if (pe0)  obs_q.push_back(mk(0, K_PE, 0, cyc));
      if (end0) obs_q.push_back(mk(0, K_END, 0, cyc));
      if (en1)  obs_q.push_back(mk(1, K_EN, int'(do1), cyc));
      if (fe1)  obs_q.push_back(mk(1, K_FE, 0, cyc));
      if (pe1)  obs_q.push_back(mk(1, K_PE, 0, cyc));
      if (end1) obs_q.push_back(mk(1, K_END, 0, cyc));
    end
  end

  task automatic check(input string tag, input int got, input int expv, input int tol);
    int diff;
    n_checks++;
    diff = (got > expv) ? got - expv : expv - got;
    if (diff > tol) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, expv, tol);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int dut, input logic v);
    logic prev;
    prev = (dut == 0) ? rx0 : rx1;
    if (dut == 0) rx0 = v;
    else rx1 = v;
    if (v && !prev) last_rise = cyc;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":do0"}, int'(do0), 0, 0);
    check({tag, ":do1"}, int'(do1), 0, 0);
    check({tag, ":en0"}, int'(en0), 0, 0);
    check({tag, ":en1"}, int'(en1), 0, 0);
    check({tag, ":fe0"}, int'(fe0), 0, 0);
    check({tag, ":fe1"}, int'(fe1), 0, 0);
    check({tag, ":pe0"}, int'(pe0), 0, 0);
    check({tag, ":pe1"}, int'(pe1), 0, 0);
    check({tag, ":end0"}, int'(end0), 0, 0);
    check({tag, ":end1"}, int'(end1), 0, 0);
  endtask

  // One character on the line; dut 1 carries a parity bit. Outcome follows the character rules only.
  task automatic send_frame(input int dut, input logic [7:0] d, input logic stop_v,
                            input logic par_flip, input int tail_low);
    int f, lat;
    f = cyc;
    set_rx(dut, 1'b0);
    idle(BC);
    for (int i = 0; i < 8; i++) begin
      set_rx(dut, d[i]);
      idle(BC);
    end
    if (dut == 1) begin
      set_rx(dut, (^d) ^ par_flip);
      idle(BC);
    end
    set_rx(dut, stop_v);
    idle(BC);
    if (tail_low > 0) idle(tail_low * BC);
    set_rx(dut, 1'b1);
    lat = (19 + 2 * dut) * BC / 2 + 4;
    last_strobe = f + lat;
    if (!stop_v) begin
      exp_q.push_back(mk(dut, K_FE, 0, f + lat));
    end else if (dut == 1 && par_flip) begin
      exp_q.push_back(mk(dut, K_PE, 0, f + lat));
    end else begin
      exp_q.push_back(mk(dut, K_EN, int'(d), f + lat));
      last_good[dut] = int'(d);
    end
    pending[dut] = 1'b1;
  endtask

  // Line now stays idle long enough for one frame_end, then all events are compared.
  task automatic end_scn(input int dut, input string name);
    int t;
    if (pending[dut]) begin
      t = (last_strobe > last_rise + 2) ? last_strobe : last_rise + 2;
      exp_q.push_back(mk(dut, K_END, 0, t + LIMIT - 1));
      pending[dut] = 1'b0;
    end
    idle(LIMIT + 60);
    check($sformatf("%s:event_count", name), obs_q.size(), exp_q.size(), 0);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s:ev%0d_dut", name, i), obs_q[i].dut, exp_q[i].dut, 0);
      check($sformatf("%s:ev%0d_kind", name, i), obs_q[i].kind, exp_q[i].kind, 0);
      if (exp_q[i].kind == K_EN && obs_q[i].kind == K_EN)
        check($sformatf("%s:ev%0d_data", name, i), obs_q[i].data, exp_q[i].data, 0);
      check($sformatf("%s:ev%0d_cycle", name, i), obs_q[i].cyc, exp_q[i].cyc,
            (exp_q[i].kind == K_END) ? 4 : 2);
    end
    check({name, ":dataout0"}, int'(do0), last_good[0], 0);
    check({name, ":dataout1"}, int'(do1), last_good[1], 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int r;
    last_good[0] = 0;
    last_good[1] = 0;
    pending[0]   = 1'b0;
    pending[1]   = 1'b0;

    idle(3);
    check_quiet("in_reset");
    rst_n = 1'b1;
    idle(5);
    check_quiet("after_reset");

    send_frame(0, 8'h02, 1'b1, 1'b0, 0);
    idle(2 * BC);
    send_frame(0, 8'h03, 1'b1, 1'b0, 0);
    end_scn(0, "two_bytes");

    send_frame(0, 8'h55, 1'b0, 1'b0, 0);
    end_scn(0, "stop_low");

    send_frame(0, 8'h00, 1'b0, 1'b0, 3);
    end_scn(0, "break");

    send_frame(1, 8'hA5, 1'b1, 1'b1, 0);
    idle(BC);
    send_frame(1, 8'hA5, 1'b1, 1'b0, 0);
    end_scn(1, "parity");

    set_rx(0, 1'b0);
    idle(5);
    set_rx(0, 1'b1);
    idle(2 * BC);
    send_frame(0, 8'h10, 1'b1, 1'b0, 0);
    end_scn(0, "glitch");

    for (int i = 0; i < 25; i++) begin
      send_frame(0, 8'($urandom), 1'b1, 1'b0, 0);
      idle(int'($urandom_range(0, 32 * BC)));
    end
    end_scn(0, "burst0");

    for (int i = 0; i < 15; i++) begin
      r = int'($urandom_range(0, 9));
      send_frame(1, 8'($urandom), (r != 0), (r == 1), 0);
      idle(int'($urandom_range(0, 20 * BC)));
    end
    end_scn(1, "burst1");

    // Reset in the middle of data bit 4.
    d = 8'hC3;
    set_rx(0, 1'b0);
    idle(BC);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, d[i]);
      idle(BC);
    end
    set_rx(0, d[4]);
    idle(BC / 2);
    #2 rst_n = 1'b0;
    #1 check_quiet("async_reset");
    @(negedge clk);
    set_rx(0, 1'b1);
    idle(3);
    rst_n = 1'b1;
    last_good[0] = 0;
    last_good[1] = 0;
    pending[0]   = 1'b0;
    pending[1]   = 1'b0;
    exp_q.delete();
    obs_q.delete();
    idle(2 * BC);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 0);
    end_scn(0, "reset_recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
